// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demux: one-entry buffer per output, route locked for a packet's duration.
// Optional build macro STREAM_DEMUX_CNT_EN adds saturating per-output delivered-beat counters on beat_cnt.

module stream_demux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic [15:0]      o_cnt
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             w_drain;

    assign w_drain = r_full && i_ready;

    // The top only loads when the slot is empty or draining, so a load always wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
        end else if (w_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_valid = r_full;
    assign o_data  = r_data;
    assign o_last  = r_last;

`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_drain && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
`else
    assign o_cnt = '0;
`endif
endmodule

module stream_demux #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_last,
    output logic                     err_drop,
    output logic [NUM_OUT*16-1:0]    beat_cnt
);
    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_lock_sel, w_lock_sel_nxt;
    logic               r_err_drop;
    logic [SEL_W-1:0]   w_route;
    logic               w_route_ok;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_hit;
    logic [NUM_OUT-1:0] w_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lock_sel <= '0;
            r_err_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
            r_err_drop <= w_accept && !w_route_ok;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_nxt    = S_LOCKED;
                    w_lock_sel_nxt = in_sel;
                end
            end
            S_LOCKED: begin
                if (w_accept && in_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Unmapped routes (non power-of-2 NUM_OUT) are always ready so the packet is swallowed.
    always_comb begin
        w_route    = (r_state == S_LOCKED) ? r_lock_sel : in_sel;
        w_route_ok = ({1'b0, w_route} < NUM_OUT_W);
        w_hit      = '0;
        in_ready   = !w_route_ok;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_hit[k] = w_route_ok && (w_route == SEL_W'(k));
            if (w_hit[k] && (!out_valid[k] || out_ready[k])) in_ready = 1'b1;
        end
        w_accept = in_valid && in_ready;
        w_load   = {NUM_OUT{w_accept}} & w_hit;
    end

    assign err_drop = r_err_drop;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        stream_demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_last  (in_last),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*WIDTH +: WIDTH]),
            .o_last  (out_last[k]),
            .o_cnt   (beat_cnt[k*16 +: 16])
        );
    end
endmodule
